// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM port arbiter: FSM state encoding,
// default requester count and the modulo helper used by the round-robin search.
package dram_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

  localparam int WORD_BYTES   = 4;
  localparam int DEFAULT_NREQ = 2;

  // (base + offset) mod n, assuming both operands are already below n
  function automatic int rr_wrap(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first asserted request starting
// at rr_ptr and wrapping around; returns it one-hot and as an index.
module rr_picker
  import dram_arb_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] index,
  output logic             any_req
);

  // cand[k] is the requester examined k-th in search order
  logic [PTR_W-1:0] cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = PTR_W'(rr_wrap(int'(rr_ptr), gi, NREQ));
    end
  endgenerate

  // Walk from the farthest candidate back to the nearest so the nearest wins
  always_comb begin
    grant   = '0;
    index   = '0;
    any_req = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant           = '0;
        grant[cand[k]]  = 1'b1;
        index           = cand[k];
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port among NREQ single-word requesters.
// Optional BUSY watchdog with reqError reporting: define DRAM_ARB_TIMEOUT_EN.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NREQ    = DEFAULT_NREQ,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0][31:0] reqAddress,
  input  logic [NREQ-1:0][31:0] reqWriteData,
  input  logic [NREQ-1:0]      reqReadEnable,
  input  logic [NREQ-1:0]      reqWriteEnable,
  output logic [31:0]          reqReadData,
  output logic [NREQ-1:0]      reqValid,
  output logic [NREQ-1:0]      reqStall,
  output logic [NREQ-1:0]      reqError,
  output logic [31:0]          dramAddress,
  output logic [31:0]          dramWriteData,
  output logic                 readEnable,
  output logic                 writeEnable,
  input  logic [31:0]          dramReadData,
  input  logic                 dramValid
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  generate
    if (TIMEOUT < 2) begin : g_bad_timeout
      $error("dram_arbiter: TIMEOUT must be at least 2");
    end
  endgenerate

  arb_state_t       state_reg, state_next;
  logic [PTR_W-1:0] grant_reg, grant_next;
  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [31:0]      rdata_reg, rdata_next;
  logic             write_reg, write_next;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  pick_grant;
  logic [PTR_W-1:0] pick_index;
  logic             any_req;

  assign req = reqReadEnable | reqWriteEnable;

  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_reg),
    .grant   (pick_grant),
    .index   (pick_index),
    .any_req (any_req)
  );

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             timed_out;
  assign timed_out = (cnt_reg == CNT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      write_reg  <= 1'b0;
`ifdef DRAM_ARB_TIMEOUT_EN
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      write_reg  <= write_next;
`ifdef DRAM_ARB_TIMEOUT_EN
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    write_next  = write_reg;
`ifdef DRAM_ARB_TIMEOUT_EN
    cnt_next    = cnt_reg;
    err_next    = err_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next = pick_index;
          addr_next  = reqAddress[pick_index];
          wdata_next = reqWriteData[pick_index];
          // A request with both enables set is treated as a write
          write_next = |(pick_grant & reqWriteEnable);
          state_next = BUSY;
`ifdef DRAM_ARB_TIMEOUT_EN
          cnt_next   = '0;
          err_next   = 1'b0;
`endif
        end
      end
      BUSY: begin
        if (dramValid) begin
          rdata_next = write_reg ? 32'h0 : dramReadData;
          state_next = RESP;
`ifdef DRAM_ARB_TIMEOUT_EN
        end else if (timed_out) begin
          rdata_next = 32'h0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
`endif
        end
      end
      RESP: begin
        rr_ptr_next = PTR_W'(rr_wrap(int'(grant_reg), 1, NREQ));
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dramAddress   = addr_reg;
  assign dramWriteData = wdata_reg;
  assign readEnable    = (state_reg == BUSY) && !write_reg;
  assign writeEnable   = (state_reg == BUSY) && write_reg;
  assign reqReadData   = rdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign reqValid[gi] = (state_reg == RESP) && (grant_reg == PTR_W'(gi));
      assign reqStall[gi] = req[gi] & ~reqValid[gi];
`ifdef DRAM_ARB_TIMEOUT_EN
      assign reqError[gi] = reqValid[gi] & err_reg;
`else
      assign reqError[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: a transaction-level model of the
// round-robin arbiter and a randomised DRAM responder drive and check the DUT.
module tb_dram_arbiter;

  localparam int N     = 2;
  localparam int TB_TO = 8;
`ifdef DRAM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0][31:0] req_address;
  logic [N-1:0][31:0] req_write_data;
  logic [N-1:0]      req_read_enable;
  logic [N-1:0]      req_write_enable;
  logic [31:0]       req_read_data;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_stall;
  logic [N-1:0]      req_error;
  logic [31:0]       dram_address;
  logic [31:0]       dram_write_data;
  logic              read_enable;
  logic              write_enable;
  logic [31:0]       dram_read_data;
  logic              dram_valid;

  int vectors     = 0;
  int miscompares = 0;
  int model_ptr   = 0;
  int last_busy   = 0;
  int txn_count   = 0;
  bit keep [N];
  int grant_log [$];

  always #5 clk = ~clk;

  dram_arbiter #(.NREQ(N), .TIMEOUT(TB_TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .reqAddress     (req_address),
    .reqWriteData   (req_write_data),
    .reqReadEnable  (req_read_enable),
    .reqWriteEnable (req_write_enable),
    .reqReadData    (req_read_data),
    .reqValid       (req_valid),
    .reqStall       (req_stall),
    .reqError       (req_error),
    .dramAddress    (dram_address),
    .dramWriteData  (dram_write_data),
    .readEnable     (read_enable),
    .writeEnable    (write_enable),
    .dramReadData   (dram_read_data),
    .dramValid      (dram_valid)
  );

  // First pending requester in round-robin order from ptr
  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  // op: 1 = read, 2 = write, 3 = both enables
  task automatic raise(input int i, input int op, input logic [31:0] addr, input logic [31:0] wd);
    req_address[i]      = addr;
    req_write_data[i]   = wd;
    req_read_enable[i]  = op[0];
    req_write_enable[i] = op[1];
  endtask

  task automatic clear_reqs();
    req_read_enable  = '0;
    req_write_enable = '0;
    for (int i = 0; i < N; i++) keep[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at a sample point of an IDLE cycle. fixed_lat: >0 fixed DRAM
  // latency, 0 random 1..5, <0 DRAM never answers.
  task automatic run_engine(input int target, input int fixed_lat, input bit use_fix,
                            input logic [31:0] fix_data, input bit rand_req, input int budget);
    int done = 0, cyc = 0, busy = 0, lat = 0, eg = 0, phase = 0;
    int drop_idx = -1, rearm_idx = -1, dropped_now;
    bit exp_wr = 0, exp_err = 0, expect_start, resp_now;
    logic [31:0] exp_addr = 0, exp_wdata = 0, rdat = 0, exp_data;
    logic [N-1:0] exp_valid, exp_errv, pend;
    logic [1:0] exp_en;
    pend = req_read_enable | req_write_enable;
    expect_start = |pend;
    while (done < target) begin
      if (cyc >= budget) begin
        vectors++; miscompares++;
        $display("FAIL engine_budget: completed %0d of %0d transactions within %0d cycles", done, target, budget);
        break;
      end
      step();
      cyc++;
      pend = req_read_enable | req_write_enable;
      resp_now = (phase == 2);
      if (phase == 0 && expect_start) begin
        eg = pick(pend, model_ptr);
        exp_wr = req_write_enable[eg];
        exp_addr = req_address[eg];
        exp_wdata = req_write_data[eg];
        grant_log.push_back(eg);
        busy = 0;
        exp_err = 1'b0;
        lat = (fixed_lat > 0) ? fixed_lat : ((fixed_lat < 0) ? 32'h00100000 : $urandom_range(1, 5));
        rdat = use_fix ? fix_data : $urandom;
        phase = 1;
      end
      exp_valid = '0;
      if (phase == 2) exp_valid[eg] = 1'b1;
      exp_errv = (phase == 2 && exp_err) ? exp_valid : '0;
      exp_en = (phase == 1) ? (exp_wr ? 2'b01 : 2'b10) : 2'b00;
      vectors++;
      if ({read_enable, write_enable} !== exp_en) begin
        miscompares++;
        $display("FAIL enables: got rd/wr=%b expected %b (cycle %0d)", {read_enable, write_enable}, exp_en, cyc);
      end
      if (phase == 1) begin
        busy++;
        vectors++;
        if (dram_address !== exp_addr) begin
          miscompares++;
          $display("FAIL dram_address: got %h expected %h", dram_address, exp_addr);
        end
        if (exp_wr) begin
          vectors++;
          if (dram_write_data !== exp_wdata) begin
            miscompares++;
            $display("FAIL dram_write_data: got %h expected %h", dram_write_data, exp_wdata);
          end
        end
      end
      vectors++;
      if (req_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL req_valid: got %b expected %b (cycle %0d)", req_valid, exp_valid, cyc);
      end
      vectors++;
      if (req_stall !== (pend & ~exp_valid)) begin
        miscompares++;
        $display("FAIL req_stall: got %b expected %b", req_stall, pend & ~exp_valid);
      end
      vectors++;
      if (req_error !== exp_errv) begin
        miscompares++;
        $display("FAIL req_error: got %b expected %b", req_error, exp_errv);
      end
      if (phase == 2) begin
        exp_data = (exp_wr || exp_err) ? 32'h0 : rdat;
        vectors++;
        if (req_read_data !== exp_data) begin
          miscompares++;
          $display("FAIL req_read_data: got %h expected %h", req_read_data, exp_data);
        end
        txn_count++;
        $display("txn %0d: grant=%0d %s addr=%h busy=%0d data=%h err=%0d",
                 txn_count, eg, exp_wr ? "WR" : "RD", exp_addr, busy, exp_data, exp_err);
        last_busy = busy;
        model_ptr = (eg + 1) % N;
        done++;
      end
      // Drive requesters for the next edge
      dropped_now = -1;
      if (rearm_idx >= 0) begin
        raise(rearm_idx, $urandom_range(1, 3), {$urandom_range(0, 255), 2'b00}, $urandom);
        rearm_idx = -1;
      end
      if (drop_idx >= 0) begin
        req_read_enable[drop_idx]  = 1'b0;
        req_write_enable[drop_idx] = 1'b0;
        if (keep[drop_idx]) rearm_idx = drop_idx;
        dropped_now = drop_idx;
        drop_idx = -1;
      end
      if (rand_req) begin
        for (int i = 0; i < N; i++) begin
          if (!(req_read_enable[i] | req_write_enable[i]) && i != dropped_now && $urandom_range(0, 2) == 0)
            raise(i, $urandom_range(1, 3), $urandom, $urandom);
        end
        if (phase == 1) begin
          req_address[eg]    = $urandom;
          req_write_data[eg] = $urandom;
        end
      end
      // Drive the DRAM side for the next edge
      if (phase == 1) begin
        if (busy == lat) begin
          dram_valid = 1'b1; dram_read_data = rdat; phase = 2;
        end else begin
          dram_valid = 1'b0; dram_read_data = $urandom;
          if (TO_EN && busy == TB_TO) begin
            exp_err = 1'b1; phase = 2;
          end
        end
      end else begin
        if (phase == 2) begin
          drop_idx = eg; phase = 0;
        end
        dram_valid = 1'($urandom_range(0, 1));
        dram_read_data = $urandom;
      end
      pend = req_read_enable | req_write_enable;
      expect_start = (phase == 0) && !resp_now && (|pend);
    end
    clear_reqs();
    dram_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_reqs();
    req_address = '0; req_write_data = '0;
    dram_valid = 1'b0; dram_read_data = 32'hDEADBEEF;
    repeat (3) step();
    vectors++;
    if ({read_enable, write_enable, req_valid, req_stall, req_error} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rd=%b wr=%b valid=%b stall=%b err=%b expected all 0",
               read_enable, write_enable, req_valid, req_stall, req_error);
    end
    vectors++;
    if ({dram_address, dram_write_data, req_read_data} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0",
               dram_address, dram_write_data, req_read_data);
    end
    reset = 1'b0;
    model_ptr = 0;
    step();
  endtask

  task automatic test_collision();
    grant_log.delete();
    raise(0, 2, 32'h200, 32'h11);
    raise(1, 1, 32'h300, 32'h0);
    run_engine(2, 0, 1'b0, 32'h0, 1'b0, 100);
    vectors++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      miscompares++;
      $display("FAIL collision_order: got %0d grants first=%0d expected order 0,1",
               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
    end
  endtask

  task automatic test_single_read();
    grant_log.delete();
    raise(0, 1, 32'h100, 32'h0);
    run_engine(1, 4, 1'b1, 32'hCAFEF00D, 1'b0, 50);
    vectors++;
    if (last_busy != 4 || grant_log.size() != 1 || grant_log[0] != 0) begin
      miscompares++;
      $display("FAIL single_read: got busy=%0d grants=%0d expected busy=4 grant 0", last_busy, grant_log.size());
    end
  endtask

  task automatic test_both_enables();
    grant_log.delete();
    raise(1, 3, 32'h40, 32'h5A5A5A5A);
    run_engine(1, 3, 1'b0, 32'h0, 1'b0, 50);
    vectors++;
    if (grant_log.size() != 1 || grant_log[0] != 1) begin
      miscompares++;
      $display("FAIL both_enables_grant: got %0d grants expected one grant to 1", grant_log.size());
    end
  endtask

  task automatic test_fairness();
    grant_log.delete();
    keep[0] = 1'b1; keep[1] = 1'b1;
    raise(0, 1, 32'h1000, 32'h0);
    raise(1, 2, 32'h2000, 32'h77);
    run_engine(6, 0, 1'b0, 32'h0, 1'b0, 200);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= grant_log.size() || grant_log[i] != (i % 2)) begin
        miscompares++;
        $display("FAIL fairness_order[%0d]: got %0d expected %0d", i,
                 i < grant_log.size() ? grant_log[i] : -1, i % 2);
      end
    end
  endtask

  task automatic test_random();
    run_engine(20, 0, 1'b0, 32'h0, 1'b1, 1000);
  endtask

  task automatic test_reset_busy();
    grant_log.delete();
    raise(0, 1, 32'h500, 32'h0);
    run_engine(1, 1, 1'b0, 32'h0, 1'b0, 30);
    raise(0, 1, 32'h80, 32'h0);
    step();
    step();
    vectors++;
    if (read_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy_pre: got readEnable=%b expected 1", read_enable);
    end
    reset = 1'b1;
    clear_reqs();
    dram_valid = 1'b0;
    step();
    model_ptr = 0;
    vectors++;
    if ({read_enable, write_enable, req_valid} !== '0 || dram_address !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_busy_drop: got rd=%b wr=%b valid=%b addr=%h expected all 0",
               read_enable, write_enable, req_valid, dram_address);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (req_valid !== '0) begin
      miscompares++;
      $display("FAIL reset_busy_novalid: got %b expected 0", req_valid);
    end
    grant_log.delete();
    raise(0, 1, 32'h84, 32'h0);
    raise(1, 1, 32'h88, 32'h0);
    run_engine(1, 2, 1'b0, 32'h0, 1'b0, 30);
    vectors++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      miscompares++;
      $display("FAIL reset_busy_ptr: got grant %0d expected 0",
               grant_log.size() > 0 ? grant_log[0] : -1);
    end
  endtask

  task automatic test_timeout();
    raise(1, 1, 32'h600, 32'h0);
    run_engine(1, -1, 1'b0, 32'h0, 1'b0, 40);
    vectors++;
    if (last_busy != TB_TO) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d busy cycles expected %0d", last_busy, TB_TO);
    end
    raise(0, 1, 32'h604, 32'h0);
    run_engine(1, TB_TO, 1'b1, 32'h0BADF00D, 1'b0, 40);
    vectors++;
    if (last_busy != TB_TO) begin
      miscompares++;
      $display("FAIL timeout_same_edge: got %0d busy cycles expected %0d", last_busy, TB_TO);
    end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_single_read();
    test_both_enables();
    test_fairness();
    test_random();
    test_reset_busy();
    if (TO_EN) test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
